relu_maxpool2d: RTL and testbench

- Streaming 2x2/stride-2 max-pool stage, with optional ReLU, directly downstream of a featuremap_conv2d_* filter block.
- Consumes that block's IEEE-754 single-precision data_out/valid_out raster stream of a WIDTH x HEIGHT feature map.
- Emits a (WIDTH/2) x (HEIGHT/2) pooled stream for the next layer's input FIFO.
- One instance per filter output.

---
 rtl/relu_maxpool2d.sv | 116 +++++++++++
 tb/tb_relu_maxpool2d.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool2d.sv
// Streaming 2x2/stride-2 max-pool over a binary32 raster stream.
// Define MAXPOOL_RELU_EN to clamp negatives to +0 before pooling.
module relu_maxpool2d #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LB = WIDTH / 2;
  localparam int LW = (LB > 1) ? $clog2(LB) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  // Returns a on ties; a zero-magnitude result is always emitted as +0.
  function automatic logic [DATA_WIDTH-1:0] pool_max(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic                  a_wins;
    logic [DATA_WIDTH-1:0] result;
    a_wins = 1'b1;
`ifdef MAXPOOL_RELU_EN
    a_wins = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]);
`else
    case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
      2'b00:   a_wins = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]);
      2'b11:   a_wins = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]);
      2'b01:   a_wins = 1'b1;
      default: a_wins = 1'b0;
    endcase
`endif
    result = a_wins ? a : b;
    if (result[DATA_WIDTH-2:0] == '0) begin
      result = '0;
    end
    return result;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] preprocess(
    input logic [DATA_WIDTH-1:0] x
  );
`ifdef MAXPOOL_RELU_EN
    return x[DATA_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] linebuf [LB];

  logic [DATA_WIDTH-1:0] pix;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic [LW-1:0]         lb_idx;
  logic                  col_last;
  logic                  row_last;

  always_comb begin
    lb_idx   = LW'(col >> 1);
    pix      = preprocess(data_in);
    pair_max = pool_max(hold, pix);
    win_max  = pool_max(linebuf[lb_idx], pair_max);
    col_last = (col == COL_LAST);
    row_last = (row == ROW_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col[0]) begin
          hold <= pix;
        end else if (row[0]) begin
          valid_out  <= 1'b1;
          data_out   <= win_max;
          frame_done <= row_last && col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Holds each top-row pair maximum until the matching bottom-row pair arrives.
  always_ff @(posedge clk) begin
    if (valid_in && col[0] && !row[0]) begin
      linebuf[lb_idx] <= pair_max;
    end
  end

endmodule

// File: tb/tb_relu_maxpool2d.sv
// Scoreboard bench for relu_maxpool2d (4x4 frames); honours MAXPOOL_RELU_EN.
module tb_relu_maxpool2d;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        frame_done;

  relu_maxpool2d #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        fd;
    int          at;
  } exp_t;

  exp_t        sb [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;
  int          n_fd = 0;
  int          r = 0;
  int          c = 0;
  logic [31:0] frame_buf [H][W];
  logic [31:0] last_out = 32'h0;
  logic [31:0] prev_rand = 32'h3F800000;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Numeric value of a non-NaN binary32, as a totally ordered integer.
  function automatic longint fval(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] model_pix(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] ref_max4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p, input logic [31:0] q);
    logic [31:0] v [4];
    logic [31:0] best;
    v[0] = a; v[1] = b; v[2] = p; v[3] = q;
    best = v[0];
    for (int i = 1; i < 4; i++) begin
      if (fval(v[i]) > fval(best)) best = v[i];
    end
    if (best[30:0] == 31'h0) best = 32'h0;
    return best;
  endfunction

  function automatic logic [31:0] rand_pix();
    logic [31:0] x;
    case ($urandom_range(0, 9))
      0:       x = 32'h00000000;
      1:       x = 32'h80000000;
      2:       x = prev_rand;
      default: x = {1'($urandom_range(0, 1)), 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
    endcase
    prev_rand = x;
    return x;
  endfunction

  // kind: 0 ramp 1.0..16.0, 1 all -2.5, 2 signed windows + random, 3 random
  function automatic logic [31:0] pixel_for(input int kind, input int idx);
    logic [31:0] ramp;
    ramp = $shortrealtobits(shortreal'(idx + 1));
    case (kind)
      0: return ramp;
      1: return 32'hC0200000;
      2: case (idx)
           0: return 32'hBF800000;
           1: return 32'hC0400000;
           2: return 32'hBF800000;
           3: return 32'hC0400000;
           4: return 32'h3F000000;
           5: return 32'hBE800000;
           6: return 32'hBF000000;
           7: return 32'hC0000000;
           default: return rand_pix();
         endcase
      default: return rand_pix();
    endcase
  endfunction

  task automatic apply_stimulus(input logic [31:0] pixel, input int gap);
    logic [31:0] p;
    repeat (gap) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
    @(posedge clk); #1;
    valid_in = 1'b1;
    data_in  = pixel;
    p = model_pix(pixel);
    frame_buf[r][c] = p;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      sb.push_back('{ref_max4(frame_buf[r-1][c-1], frame_buf[r-1][c], frame_buf[r][c-1], p),
                     (r == H - 1) && (c == W - 1), cyc + 1});
    end
    if (c == W - 1) begin
      c = 0;
      r = (r == H - 1) ? 0 : r + 1;
    end else begin
      c = c + 1;
    end
  endtask

  task automatic send_frame(input int kind, input int max_gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      apply_stimulus(pixel_for(kind, i), (i == 0) ? 0 : int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    idle(1);
    while (sb.size() != 0 && budget < 10) begin
      idle(1);
      budget++;
    end
    check_output("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic apply_reset(input int n);
    idle(1);
    check_output("pending_at_reset", 32'(sb.size()), 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
    r = 0;
    c = 0;
  endtask

  // Monitor: every cycle either matches the scoreboard head or must stay quiet.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      check_output("reset_valid", {31'b0, valid_out}, 32'h0);
      check_output("reset_data", data_out, 32'h0);
      check_output("reset_fd", {31'b0, frame_done}, 32'h0);
      last_out = 32'h0;
    end else if (valid_out) begin
      n_valid++;
      if (frame_done) n_fd++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out actual=%h expected=none (cycle %0d)", data_out, cyc);
      end else begin
        e = sb.pop_front();
        check_output("data_out", data_out, e.data);
        check_output("frame_done", {31'b0, frame_done}, {31'b0, e.fd});
        check_output("latency", 32'(cyc), 32'(e.at));
      end
      last_out = data_out;
    end else begin
      check_output("hold_data", data_out, last_out);
      check_output("fd_without_valid", {31'b0, frame_done}, 32'h0);
    end
  end

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(10);

    $display("[TB] basic ramp, contiguous");
    n_valid = 0; n_fd = 0;
    send_frame(0, 0, W * H);
    drain();
    check_output("ramp_valid_count", 32'(n_valid), 32'd4);
    check_output("ramp_fd_count", 32'(n_fd), 32'd1);

    $display("[TB] constant -2.5 frame");
    send_frame(1, 0, W * H);
    drain();

    $display("[TB] signed windows");
    send_frame(2, 0, W * H);
    drain();

    $display("[TB] gappy back-to-back frames");
    n_valid = 0; n_fd = 0;
    send_frame(0, 3, W * H);
    send_frame(0, 3, W * H);
    drain();
    check_output("gappy_valid_count", 32'(n_valid), 32'd8);
    check_output("gappy_fd_count", 32'(n_fd), 32'd2);

    $display("[TB] reset mid-frame");
    send_frame(0, 0, 7);
    apply_reset(2);
    n_valid = 0; n_fd = 0;
    send_frame(0, 0, W * H);
    drain();
    check_output("post_reset_valid_count", 32'(n_valid), 32'd4);

    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      send_frame(3, (f < 6) ? 0 : 2, W * H);
    end
    drain();

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
